// File: rtl/operand_stage.sv
// rtl/operand_stage.sv - register file read and operand register feeding the ALU.
// Optional same-cycle writeback bypass enabled by OPSTAGE_WB_BYPASS_EN.
module operand_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  input  logic        use_imm,
  input  logic        use_shamt,
  input  logic [3:0]  alusel_in,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] opA,
  output logic [31:0] opB,
  output logic [3:0]  alusel
);

  logic [31:0] regFile [32];
  logic        wbWrite;
  logic        capture;
  logic [31:0] rsVal;
  logic [31:0] rtVal;
  logic [31:0] nextA;
  logic [31:0] nextB;

  assign wbWrite  = wb_en && (wb_addr != 5'd0);
  assign in_ready = ~out_valid | out_ready;
  assign capture  = in_valid & in_ready;

  always_comb begin
    rsVal = (rs == 5'd0) ? 32'd0 : regFile[rs];
    rtVal = (rt == 5'd0) ? 32'd0 : regFile[rt];
`ifdef OPSTAGE_WB_BYPASS_EN
    // wbWrite already excludes register 0, so R0 is never forwarded
    if (wbWrite && (wb_addr == rs)) rsVal = wb_data;
    if (wbWrite && (wb_addr == rt)) rtVal = wb_data;
`else
`endif
    nextA = use_shamt ? {27'd0, shamt} : rsVal;
    nextB = use_imm ? {{16{imm[15]}}, imm} : rtVal;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regFile[i] <= 32'd0;
    end else if (wbWrite) begin
      regFile[wb_addr] <= wb_data;
    end
  end

  // Consume without capture only drops valid; operand values are left as they were
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      opA       <= 32'd0;
      opB       <= 32'd0;
      alusel    <= 4'd0;
    end else if (capture) begin
      out_valid <= 1'b1;
      opA       <= nextA;
      opB       <= nextB;
      alusel    <= alusel_in;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_stage.sv
// tb/tb_operand_stage.sv - directed self-checking bench for operand_stage.
module tb_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  shamt;
  logic [15:0] imm;
  logic        use_imm;
  logic        use_shamt;
  logic [3:0]  alusel_in;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] opA;
  logic [31:0] opB;
  logic [3:0]  alusel;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] bypassExp;

  operand_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rs(rs), .rt(rt), .shamt(shamt), .imm(imm), .use_imm(use_imm),
    .use_shamt(use_shamt), .alusel_in(alusel_in), .wb_en(wb_en),
    .wb_addr(wb_addr), .wb_data(wb_data), .out_valid(out_valid),
    .out_ready(out_ready), .opA(opA), .opB(opB), .alusel(alusel)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    step();
    wb_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; rs = 0; rt = 0; shamt = 0; imm = 0;
    use_imm = 0; use_shamt = 0; alusel_in = 0; wb_en = 0; wb_addr = 0;
    wb_data = 0; out_ready = 1;
    #3;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_opA", opA, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;

    wr(5'd5, 32'h0000_00FF);
    wr(5'd6, 32'hFFFF_FF00);

    in_valid = 1; rs = 5; rt = 6; alusel_in = 4'b0001;
    step();
    check("cap_valid", {31'd0, out_valid}, 32'd1);
    check("cap_opA", opA, 32'h0000_00FF);
    check("cap_opB", opB, 32'hFFFF_FF00);
    check("cap_alusel", {28'd0, alusel}, 32'd1);

    use_shamt = 1; shamt = 5'd4; rt = 5;
    step();
    check("shamt_opA", opA, 32'h0000_0004);
    check("shamt_opB", opB, 32'h0000_00FF);

    use_imm = 1; imm = 16'h8001;
    step();
    check("imm_opA", opA, 32'h0000_0004);
    check("imm_opB", opB, 32'hFFFF_8001);

    in_valid = 0; use_shamt = 0; use_imm = 0;
    wr(5'd0, 32'hDEAD_BEEF);
    check("drain_valid", {31'd0, out_valid}, 32'd0);
    check("drain_opA_hold", opA, 32'h0000_0004);

    // Capture rs=0 while another write to R0 is in flight: R0 must read 0 either way
    in_valid = 1; rs = 0; rt = 0; alusel_in = 4'h2;
    wb_en = 1; wb_addr = 0; wb_data = 32'hDEAD_BEEF;
    step();
    wb_en = 0;
    check("r0_opA", opA, 32'd0);
    check("r0_opB", opB, 32'd0);

    rs = 5; rt = 6; alusel_in = 4'h2;
    step();
    check("pre_stall_opA", opA, 32'h0000_00FF);

    out_ready = 0; rs = 6; rt = 5; alusel_in = 4'h3;
    wb_en = 1; wb_addr = 5; wb_data = 32'h0000_1234;
    #1;
    check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      wb_en = 0;
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      check("stall_opA", opA, 32'h0000_00FF);
      check("stall_opB", opB, 32'hFFFF_FF00);
      check("stall_alusel", {28'd0, alusel}, 32'h2);
    end

    out_ready = 1;
    step();
    check("resume_valid", {31'd0, out_valid}, 32'd1);
    check("resume_opA", opA, 32'hFFFF_FF00);
    check("resume_opB", opB, 32'h0000_1234);
    check("resume_alusel", {28'd0, alusel}, 32'h3);

    in_valid = 0;
    wr(5'd7, 32'h0000_0555);
    in_valid = 1; rs = 7; rt = 0; alusel_in = 4'h4;
    wb_en = 1; wb_addr = 7; wb_data = 32'h0000_0AAA;
`ifdef OPSTAGE_WB_BYPASS_EN
    bypassExp = 32'h0000_0AAA;
`else
    bypassExp = 32'h0000_0555;
`endif
    step();
    wb_en = 0;
    check("bypass_opA", opA, bypassExp);

    rs = 5; rt = 6; alusel_in = 4'h5;
    step();
    in_valid = 0; out_ready = 0;
    step();
    check("rst_stall_valid", {31'd0, out_valid}, 32'd1);
    #1;
    rst = 1;
    #1;
    check("async_valid", {31'd0, out_valid}, 32'd0);
    check("async_opA", opA, 32'd0);
    check("async_opB", opB, 32'd0);
    check("async_alusel", {28'd0, alusel}, 32'd0);
    check("async_in_ready", {31'd0, in_ready}, 32'd1);

    in_valid = 1; wb_en = 1; wb_addr = 9; wb_data = 32'h0000_0005;
    step();
    check("rst_no_capture", {31'd0, out_valid}, 32'd0);
    wb_en = 0; in_valid = 0;
    #2;
    rst = 0;
    in_valid = 1; rs = 5; rt = 9; alusel_in = 4'h6;
    step();
    check("post_rst_valid", {31'd0, out_valid}, 32'd1);
    check("post_rst_R5", opA, 32'd0);
    check("post_rst_R9", opB, 32'd0);
    check("post_rst_alusel", {28'd0, alusel}, 32'h6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/operand_stage.md
OPERAND_STAGE -- requirements
Module: operand_stage

Interface
REQ-001 The module SHALL have the port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-002 The module SHALL have the port rst, input, 1 bit, asynchronous active-high reset.
REQ-003 The module SHALL have the port in_valid, input, 1 bit, meaning a decoded instruction is presented.
REQ-004 The module SHALL have the port in_ready, output, 1 bit, meaning the stage accepts the presented instruction this cycle.
REQ-005 The module SHALL have the port rs, input, 5 bits, the first source register address.
REQ-006 The module SHALL have the port rt, input, 5 bits, the second source register address.
REQ-007 The module SHALL have the port shamt, input, 5 bits, the shift amount field.
REQ-008 The module SHALL have the port imm, input, 16 bits, the immediate field.
REQ-009 The module SHALL have the port use_imm, input, 1 bit, which selects the extended immediate for opB.
REQ-010 The module SHALL have the port use_shamt, input, 1 bit, which selects the zero-extended shamt for opA.
REQ-011 The module SHALL have the port alusel_in, input, 4 bits, the ALU operation code, passed through unchanged.
REQ-012 The module SHALL have the port wb_en, input, 1 bit, the writeback enable.
REQ-013 The module SHALL have the port wb_addr, input, 5 bits, the writeback register address.
REQ-014 The module SHALL have the port wb_data, input, 32 bits, the writeback data.
REQ-015 The module SHALL have the port out_valid, output, 1 bit, meaning the operand register holds a valid instruction.
REQ-016 The module SHALL have the port out_ready, input, 1 bit, meaning the ALU stage consumes the output this cycle.
REQ-017 The module SHALL have the ports opA and opB, outputs, 32 bits each, and the port alusel, output, 4 bits, all registered and all driving the ALU directly.

Function
REQ-018 The register file SHALL hold 32 words of 32 bits each, and register 0 SHALL always read 0.
REQ-019 A write SHALL occur at the clock edge when wb_en=1 and wb_addr!=0; a write to register 0 SHALL be discarded; writes SHALL be independent of stall state.
REQ-020 in_ready SHALL equal (~out_valid | out_ready), combinationally.
REQ-021 A capture SHALL occur when in_valid & in_ready; at that edge, opA, opB, alusel SHALL be loaded and out_valid SHALL be set to 1; the latency SHALL be 1 cycle.
REQ-022 On a capture, opA SHALL be {27'b0, shamt} when use_shamt=1, else R[rs].
REQ-023 On a capture, opB SHALL be {{16{imm[15]}}, imm} when use_imm=1, else R[rt]; use_shamt and use_imm MAY both be 1.
REQ-024 When out_valid & out_ready & no capture, out_valid SHALL clear to 0, and opA/opB/alusel SHALL hold their values.
REQ-025 When out_valid=1 & out_ready=0, all outputs SHALL hold; a writeback to rs or rt SHALL NOT alter held operands.
REQ-026 Simultaneous consume and capture SHALL reload the register with no bubble, and out_valid SHALL stay 1.
REQ-027 in_valid=0 SHALL leave the operand register unchanged apart from REQ-024.

Reset
REQ-028 On rst=1, out_valid, opA, opB, alusel and all 32 registers SHALL clear to 0 immediately and asynchronously.
REQ-029 While rst=1, in_ready SHALL read 1, captures SHALL be ignored, and writebacks SHALL be ignored.
REQ-030 On reset mid-stall, the pending output SHALL be discarded, and the first edge after release SHALL accept new input.

Configuration
REQ-031 The macro OPSTAGE_WB_BYPASS_EN SHALL control write-to-read bypass.
REQ-032 With OPSTAGE_WB_BYPASS_EN defined, a capture in the same cycle as a write to rs/rt (address !=0) SHALL use wb_data.
REQ-033 Without OPSTAGE_WB_BYPASS_EN, a capture in the same cycle as a write to rs/rt SHALL use the pre-write register value.
REQ-034 Register 0 SHALL never be bypassed in either configuration.

Verification
REQ-035 The bench SHALL cover: write R5=0x0000_00FF, R6=0xFFFF_FF00; capture rs=5, rt=6, alusel_in=4'b0001 -> next cycle out_valid=1, opA=0x0000_00FF, opB=0xFFFF_FF00, alusel=4'b0001.
REQ-036 The bench SHALL cover: use_shamt=1, shamt=4, rt=5, use_imm=0 -> opA=0x0000_0004, opB=0x0000_00FF; use_imm=1, imm=0x8001 -> opB=0xFFFF_8001.
REQ-037 The bench SHALL cover: wb_en=1, wb_addr=0, wb_data=0xDEAD_BEEF, then capture rs=0 -> opA=0x0000_0000.
REQ-038 The bench SHALL cover: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable, no capture; with a write R5=0x1234 during the stall -> held opA unchanged; then out_ready=1 with in_valid=1 -> back-to-back capture, out_valid stays 1.
REQ-039 The bench SHALL cover: same-cycle wb R7=0x0000_0AAA and capture rs=7 -> opA=0x0000_0AAA with OPSTAGE_WB_BYPASS_EN defined, and opA=old R7 without it.
REQ-040 The bench SHALL cover: rst asserted mid-stall with out_valid=1 -> out_valid, opA, opB and alusel =0 before the next edge, R5 reads 0 after release.
